// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - stream loader and checksum verifier for the SAP-1 16x8 RAM
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   start, abort, length   load control; length sampled with start (0 or >16 means 16)
//   in_valid/in_data/in_ready   byte stream into the loader
//   wr_en/wr_address/wr_data    RAM write port, one strobe per accepted byte
//   rd_ce/rd_address/rd_data    RAM read port, rd_ce active-low
//   busy                   load or verify in progress (CPU hold)
//   done                   one-cycle pulse at the end of verify
//   error                  readback checksum mismatch, held until the next start
//   checksum               running 8-bit sum of the bytes written
module ram_loader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   length,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_address,
  output logic [DW-1:0] wr_data,
  output logic          rd_ce,
  output logic [AW-1:0] rd_address,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] checksum
);

  localparam logic [AW:0] DEPTH_N = (AW+1)'(1 << AW);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    V_ADDR,
    V_SAMPLE,
    CHECK
  } state_t;

  state_t        state;
  logic [AW:0]   n_len;   // bytes to load this run, 1..16
  logic [AW:0]   cnt;     // bytes written, then bytes read back
  logic [DW-1:0] rdsum;

  // A zero length means a full RAM; anything larger than the RAM is clamped.
  logic [AW:0] length_eff;
  assign length_eff = (length == '0 || length > DEPTH_N) ? DEPTH_N : length;

  logic cnt_last;
  assign cnt_last = (cnt == n_len - ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n_len      <= '0;
      cnt        <= '0;
      rdsum      <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
      rd_ce      <= 1'b1;
      rd_address <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (abort) begin
        // Leaves error and checksum as they were so the host can inspect them.
        state    <= IDLE;
        busy     <= 1'b0;
        in_ready <= 1'b0;
        rd_ce    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              n_len    <= length_eff;
              cnt      <= '0;
              checksum <= '0;
              rdsum    <= '0;
              error    <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= LOAD;
            end
          end
          LOAD: begin
            if (in_valid && in_ready) begin
              wr_en      <= 1'b1;
              wr_address <= cnt[AW-1:0];
              wr_data    <= in_data;
              checksum   <= checksum + in_data;
              cnt        <= cnt + ONE;
              if (cnt_last) begin
                in_ready <= 1'b0;
                state    <= FLUSH;
              end
            end
          end
          FLUSH: begin
            // The last write strobe is on the bus during this cycle.
            cnt   <= '0;
            state <= V_ADDR;
          end
          V_ADDR: begin
            rd_ce      <= 1'b0;
            rd_address <= cnt[AW-1:0];
            state      <= V_SAMPLE;
          end
          V_SAMPLE: begin
            // RAM read is combinational from rd_address, so data is valid now.
            rdsum <= rdsum + rd_data;
            cnt   <= cnt + ONE;
            if (cnt_last) begin
              rd_ce <= 1'b1;
              state <= CHECK;
            end else begin
              state <= V_ADDR;
            end
          end
          CHECK: begin
            error <= (rdsum != checksum);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader
module tb_ram_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] wr_address;
  logic [7:0] wr_data;
  logic       rd_ce;
  logic [3:0] rd_address;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  ram_loader #(.AW(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .rd_ce(rd_ce), .rd_address(rd_address), .rd_data(rd_data),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // RAM model: synchronous write, combinational read, optional fault at address 2.
  logic [7:0] mem [16];
  bit         corrupt = 1'b0;
  always @(posedge clk) if (wr_en) mem[wr_address] <= wr_data;
  assign rd_data = (corrupt && rd_address == 4'd2) ? 8'hFF : mem[rd_address];

  logic [7:0] stream [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the outputs must be, derived from the
  // handshake rule, the 2-cycles-per-byte verify and the end-of-verify timing.
  bit         m_active, m_loading, m_wr, m_err;
  logic [7:0] m_wa, m_wd, m_sum, m_rd_sum;
  logic [7:0] m_data [16];
  int         m_n, m_cnt, m_done_at, m_rd_lo, m_rd_hi;

  function automatic int clamp_len(input int len);
    return (len == 0 || len > 16) ? 16 : len;
  endfunction

  task automatic model_init();
    m_active = 0; m_loading = 0; m_wr = 0; m_err = 0;
    m_sum = 8'h00; m_cnt = 0; m_n = 0;
    m_done_at = -1; m_rd_lo = 1; m_rd_hi = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      model_init();
    end else begin
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      if (m_wr) begin
        chk("wr_address", 32'(wr_address), 32'(m_wa));
        chk("wr_data", 32'(wr_data), 32'(m_wd));
      end
      chk("in_ready", 32'(in_ready), 32'(m_loading));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(edge_n == m_done_at));
      chk("checksum", 32'(checksum), 32'(m_sum));
      chk("error", 32'(error), 32'(m_err));
      chk("rd_ce", 32'(rd_ce), 32'(!(edge_n >= m_rd_lo && edge_n <= m_rd_hi)));
      if (edge_n >= m_rd_lo && edge_n <= m_rd_hi)
        chk("rd_address", 32'(rd_address), 32'((edge_n - m_rd_lo) / 2));

      // Predict the effect of the coming rising edge.
      m_wr = 0;
      if (abort) begin
        if (m_active) begin
          m_active = 0; m_loading = 0;
          m_done_at = -1; m_rd_lo = 1; m_rd_hi = 0;
        end
      end else begin
        if (m_loading && in_valid) begin
          m_wr = 1; m_wa = 8'(m_cnt); m_wd = in_data;
          m_data[m_cnt] = in_data;
          m_sum = m_sum + in_data;
          m_cnt++;
          if (m_cnt == m_n) begin
            m_loading = 0;
            m_rd_lo = edge_n + 1 + 2;
            m_rd_hi = edge_n + 1 + 2 * m_n;
            m_done_at = edge_n + 1 + 2 * m_n + 2;
            m_rd_sum = 8'h00;
            for (int k = 0; k < m_n; k++)
              m_rd_sum = m_rd_sum + ((corrupt && k == 2) ? 8'hFF : m_data[k]);
          end
        end
        if (start && !m_active) begin
          m_active = 1; m_loading = 1; m_n = clamp_len(int'(length));
          m_cnt = 0; m_sum = 8'h00; m_err = 0;
        end else if (edge_n + 1 == m_done_at) begin
          m_active = 0;
          m_err = (m_rd_sum != m_sum);
        end
      end
    end
  end

  // Driver tasks: called and return at posedge + 1.
  task automatic kick(input int len, output int t0);
    start = 1'b1; length = 5'(len);
    @(posedge clk); #1;
    start = 1'b0; t0 = edge_n;
  endtask

  task automatic feed(input int n, input bit bp, input int abort_after);
    int idx;
    bit hs;
    idx = 0;
    for (int c = 0; c < 400 && idx < n; c++) begin
      if (idx == abort_after) begin
        abort = 1'b1; in_valid = 1'b1; in_data = stream[idx];
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_checksum", 32'(checksum), 32'h3E);
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done), 32'd0);
        end
        return;
      end
      in_valid = bp ? (c % 3 == 0) : 1'b1;
      in_data = stream[idx];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    chk("load_count", 32'(idx), 32'(n));
  endtask

  task automatic wait_done(input int t0, input int exp_rel, input logic [7:0] exp_sum, input bit exp_err);
    bit got;
    int dedge;
    got = 0; dedge = 0;
    for (int c = 0; c < 300; c++) begin
      if (done) begin got = 1; dedge = edge_n; break; end
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      if (exp_rel > 0) chk("done_cycle", 32'(dedge - t0 + 1), 32'(exp_rel));
      chk("final_checksum", 32'(checksum), 32'(exp_sum));
      chk("final_error", 32'(error), 32'(exp_err));
    end
  endtask

  task automatic check_mem(input int n);
    for (int i = 0; i < n; i++) chk("mem", 32'(mem[i]), 32'(stream[i]));
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_address", 32'(wr_address), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_rd_ce", 32'(rd_ce), 32'd1);
    chk("rst_rd_address", 32'(rd_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int t0;
    bit seen;
    logic [7:0] s;
    reset = 1'b1; start = 1'b0; abort = 1'b0; length = 5'd0;
    in_valid = 1'b0; in_data = 8'h00;
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Full 16-byte load via length 0.
    stream = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
               8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04};
    kick(0, t0);
    feed(16, 1'b0, -1);
    wait_done(t0, 51, 8'h50, 1'b0);
    check_mem(16);

    // Short load of 4 bytes.
    stream[0] = 8'h0D; stream[1] = 8'h1B; stream[2] = 8'hE0; stream[3] = 8'hF0;
    @(posedge clk); #1;
    kick(4, t0);
    feed(4, 1'b0, -1);
    wait_done(t0, 15, 8'hF8, 1'b0);
    chk("mem4_untouched", 32'(mem[4]), 32'hE0);

    // Readback corruption at address 2.
    corrupt = 1'b1;
    @(posedge clk); #1;
    kick(4, t0);
    feed(4, 1'b0, -1);
    wait_done(t0, 15, 8'hF8, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    chk("error_held", 32'(error), 32'd1);
    corrupt = 1'b0;

    // Backpressure with in_valid pattern 1,0,0.
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      stream[i] = 8'(i * 7 + 3);
      s = s + stream[i];
    end
    kick(16, t0);
    chk("error_cleared", 32'(error), 32'd0);
    feed(16, 1'b1, -1);
    wait_done(t0, 0, s, 1'b0);
    check_mem(16);

    // Abort after 3 handshakes, then an oversize length clamps to 16.
    stream = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
               8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04};
    kick(16, t0);
    feed(16, 1'b0, 3);
    kick(20, t0);
    feed(16, 1'b0, -1);
    wait_done(t0, 51, 8'h50, 1'b0);
    check_mem(16);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; length = 5'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_ready", 32'(in_ready), 32'd0);

    // Asynchronous reset during verify.
    stream[0] = 8'h0D; stream[1] = 8'h1B; stream[2] = 8'hE0; stream[3] = 8'hF0;
    @(posedge clk); #1;
    kick(4, t0);
    feed(4, 1'b0, -1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (!rd_ce) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("verify_reached", 32'(seen), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    check_reset_outputs();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle_busy", 32'(busy), 32'd0);
    chk("post_reset_idle_ready", 32'(in_ready), 32'd0);
    kick(4, t0);
    feed(4, 1'b0, -1);
    wait_done(t0, 15, 8'hF8, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Programs the SAP-1 16x8 program/data RAM from an external byte stream, which replaces the fixed reset-time program image.
- Accepts a valid/ready byte stream and drives a synchronous write port: address, data and write strobe.
- After loading, reads every written location back over the RAM's existing read interface (CE active-low, address, data out) and compares an 8-bit additive checksum.
- Sits between the host/debug stream and the RAM. busy holds the CPU in reset while loading.

Parameters:
- AW, 4, address width; depth = 2**AW = 16.
- DW, 8, data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  cancel the current load/verify; return to IDLE.
- length  input  AW+1  number of bytes to load; sampled with start.
- in_valid  input  1  stream byte valid.
- in_data  input  DW  stream byte.
- in_ready  output  1  loader can accept a byte.
- wr_en  output  1  RAM write strobe, one cycle per byte.
- wr_address  output  AW  RAM write address.
- wr_data  output  DW  RAM write data.
- rd_ce  output  1  RAM read enable, active-low.
- rd_address  output  AW  RAM read address.
- rd_data  input  DW  RAM read data (RAM output).
- busy  output  1  load or verify in progress; used as CPU hold.
- done  output  1  one-cycle pulse when verify completes.
- error  output  1  checksum mismatch flag; held until next start.
- checksum  output  DW  running checksum of bytes written.

Behaviour:
- Reset (reset=0, asynchronous) forces every output immediately:
  - in_ready=0, wr_en=0, wr_address=0, wr_data=0.
  - rd_ce=1, rd_address=0.
  - busy=0, done=0, error=0, checksum=0.
  - State = IDLE.
- All outputs are registered.
- States: IDLE, LOAD, FLUSH, V_ADDR, V_SAMPLE, CHECK.
- IDLE:
  - in_ready=0; in_valid is ignored.
  - On start=1: latch N = length, with 0 mapped to 16 and values >16 clamped to 16.
  - Clear the byte counter, checksum, read-sum and error; set busy=1; go to LOAD.
- LOAD:
  - in_ready=1.
  - Handshake = in_valid & in_ready at a rising edge.
  - Each handshake registers wr_en=1, wr_address=cnt, wr_data=in_data. The write is visible the cycle after the handshake, i.e. latency 1.
  - Each handshake also sets checksum += in_data (mod 2**DW) and cnt += 1.
  - Cycles without a handshake have wr_en=0.
  - After the N-th handshake: in_ready=0, go to FLUSH.
- FLUSH: one cycle, carrying the final wr_en pulse. Then clear cnt and go to V_ADDR.
- V_ADDR:
  - rd_ce=0, rd_address=cnt; go to V_SAMPLE.
- V_SAMPLE:
  - rd_ce stays 0.
  - Sample rd_data: rdsum += rd_data, cnt += 1.
  - If cnt was N-1 go to CHECK, else go to V_ADDR.
  - Verify costs 2 cycles per byte.
- CHECK:
  - rd_ce=1.
  - error <= (rdsum != checksum); done <= 1 for one cycle; busy <= 0; go to IDLE.
- Timing with in_valid held high and start sampled at edge 0:
  - Writes occur in cycles 2..N+1.
  - done is high in cycle 3N+3.
- abort:
  - In any non-IDLE state, at the next edge: go to IDLE, busy=0, in_ready=0, wr_en=0, rd_ce=1, done=0.
  - error and checksum are left unchanged.
  - RAM contents after an abort are partial and undefined.
- Ignored inputs: start while busy; in_valid outside LOAD.
- Priority order: reset > abort > normal progress.
- Address wrap: never occurs; cnt saturates at N ≤ 16.
- Simultaneous start and abort in IDLE: abort wins; stay in IDLE.

Test Plan:
- Load length=0 (interpreted as 16), stream 09 1A 1B 2C E0 F0 00 00 00 01 02 03 04 04 04 04 with in_valid held high. Required:
  - 16 wr_en pulses at addresses 0..15 with matching data.
  - checksum=8'h50.
  - 16 reads with rd_ce=0.
  - done pulse in cycle 51, error=0.
- Load length=4, stream 0D 1B E0 F0. Required:
  - Writes only to addresses 0..3; reads only 0..3.
  - checksum=8'hF8, done in cycle 15, error=0.
- Readback corruption: RAM model returns 8'hFF at address 2 during the length=4 load. Required: error=1 with done; error stays 1 until the next start.
- Backpressure: in_valid toggles 1,0,0,1,...
  - No wr_en in gap cycles.
  - wr_address increments only on handshakes.
  - Final memory equals the stream.
- abort after 3 handshakes. Required:
  - Next cycle: busy=0, in_ready=0, wr_en=0, no done.
  - A new start with length=20 (clamped to 16) loads 16 bytes.
- reset=0 asserted asynchronously mid-V_SAMPLE. Required: all outputs at reset values before the next clock edge; state IDLE after release.
